grf_wb_queue: RTL and testbench

Write-back queue sitting between the execution stages and the general register file's single write port. Producers with variable latency (ALU, load path, multiply/divide) push register write requests through a valid/ready handshake. The block buffers them in order in a small FIFO and drains at most one per cycle onto the register-file write port (write enable, PC, destination address, data). It also answers a forwarding query: the youngest value still pending for a given register.

---
 rtl/grf_wb_pkg.sv | 25 ++
 rtl/grf_wb_fifo.sv | 73 +++++++
 rtl/grf_wb_queue.sv | 123 ++++++++++++
 tb/tb_grf_wb_queue.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/grf_wb_pkg.sv
// Shared constants for the GRF write-back queue: default sizes, entry field
// layout inside a FIFO word, and the hard-wired zero register.
package grf_wb_pkg;

  localparam int WB_DEPTH = 4;
  localparam int WB_AW    = 5;
  localparam int WB_DW    = 32;
  localparam int ZERO_REG = 0;

  // A FIFO word is {pc, addr, data}, with data in the least-significant bits.
  localparam int DATA_LSB = 0;

  function automatic int addr_lsb(input int dw);
    return dw;
  endfunction

  function automatic int pc_lsb(input int aw, input int dw);
    return dw + aw;
  endfunction

  function automatic int entry_w(input int aw, input int dw);
    return dw + aw + dw;
  endfunction

endpackage

// File: rtl/grf_wb_fifo.sv
// In-order storage for pending register writes. Pointers carry one extra wrap
// bit so full and empty are told apart without a separate counter register.
module grf_wb_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [W-1:0]            wdata_i,
  output logic [W-1:0]            rdata_o,
  output logic [DEPTH-1:0][W-1:0] entries_o,
  output logic [DEPTH-1:0]        valid_o,
  output logic [PW-1:0]           head_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [PW:0]             count_o
);

  localparam int CW = PW + 1;

  logic [PW:0]             head_q, head_d;
  logic [PW:0]             tail_q, tail_d;
  logic [DEPTH-1:0][W-1:0] mem_q;
  logic                    do_push;
  logic                    do_pop;

  assign full_o  = (head_q[PW] != tail_q[PW]) && (head_q[PW-1:0] == tail_q[PW-1:0]);
  assign empty_o = (head_q == tail_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_d  = head_q + CW'(do_pop);
  assign tail_d  = tail_q + CW'(do_push);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // decide which slots hold live data, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q[PW-1:0]] <= wdata_i;
  end

  assign rdata_o   = mem_q[head_q[PW-1:0]];
  assign entries_o = mem_q;
  assign head_o    = head_q[PW-1:0];
  assign count_o   = tail_q - head_q;

  logic [PW-1:0] age;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    valid_o = '0;
    age     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age        = PW'(i) - head_q[PW-1:0];
      valid_o[i] = ({1'b0, age} < count_o);
    end
  end

endmodule

// File: rtl/grf_wb_queue.sv
// Write-back queue in front of the single GRF write port: buffers producer
// writes in order, drains one per cycle, and forwards the youngest pending value.
module grf_wb_queue
  import grf_wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_pc,
  input  logic [AW-1:0]          in_addr,
  input  logic [DW-1:0]          in_data,
  input  logic                   drain_en,
  output logic                   grf_we,
  output logic [DW-1:0]          grf_pc,
  output logic [AW-1:0]          grf_a3,
  output logic [DW-1:0]          grf_wd,
  input  logic [AW-1:0]          q_addr,
  output logic                   q_hit,
  output logic [DW-1:0]          q_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW    = $clog2(DEPTH);
  localparam int EW    = entry_w(AW, DW);
  localparam int A_LSB = addr_lsb(DW);
  localparam int P_LSB = pc_lsb(AW, DW);

  logic [EW-1:0]             head_entry;
  logic [DEPTH-1:0][EW-1:0]  entries;
  logic [DEPTH-1:0]          valid;
  logic [PW-1:0]             head_idx;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      do_pop;

  grf_wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (in_valid),
    .pop_i     (drain_en),
    .wdata_i   ({in_pc, in_addr, in_data}),
    .rdata_o   (head_entry),
    .entries_o (entries),
    .valid_o   (valid),
    .head_o    (head_idx),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (count)
  );

  assign in_ready = !fifo_full;
  assign do_pop   = drain_en && !fifo_empty;

  logic          grf_we_q, grf_we_d;
  logic [DW-1:0] grf_pc_q, grf_pc_d;
  logic [AW-1:0] grf_a3_q, grf_a3_d;
  logic [DW-1:0] grf_wd_q, grf_wd_d;

  // Address/data/PC hold their last values when nothing pops; only we drops.
  always_comb begin
    grf_we_d = do_pop;
    grf_pc_d = grf_pc_q;
    grf_a3_d = grf_a3_q;
    grf_wd_d = grf_wd_q;
    if (do_pop) begin
      grf_pc_d = head_entry[P_LSB +: DW];
      grf_a3_d = head_entry[A_LSB +: AW];
      grf_wd_d = head_entry[DATA_LSB +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grf_we_q <= 1'b0;
      grf_pc_q <= '0;
      grf_a3_q <= '0;
      grf_wd_q <= '0;
    end else begin
      grf_we_q <= grf_we_d;
      grf_pc_q <= grf_pc_d;
      grf_a3_q <= grf_a3_d;
      grf_wd_q <= grf_wd_d;
    end
  end

  assign grf_we = grf_we_q;
  assign grf_pc = grf_pc_q;
  assign grf_a3 = grf_a3_q;
  assign grf_wd = grf_wd_q;

  logic [PW-1:0] slot;

  // Walk oldest to youngest so later matches override; output stage is weakest.
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    slot   = '0;
    if (grf_we_q && (grf_a3_q == q_addr)) begin
      q_hit  = 1'b1;
      q_data = grf_wd_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      slot = head_idx + PW'(i);
      if (valid[slot] && (entries[slot][A_LSB +: AW] == q_addr)) begin
        q_hit  = 1'b1;
        q_data = entries[slot][DATA_LSB +: DW];
      end
    end
    if (q_addr == AW'(ZERO_REG)) begin
      q_hit  = 1'b0;
      q_data = '0;
    end
  end

endmodule

// File: tb/tb_grf_wb_queue.sv
// Directed bench for grf_wb_queue: latency, backpressure, wrap, forwarding
// priority, zero-register handling and mid-operation reset.
module tb_grf_wb_queue;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        drain_en;
  logic        grf_we;
  logic [31:0] grf_pc;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [4:0]  q_addr;
  logic        q_hit;
  logic [31:0] q_data;
  logic [2:0]  count;

  int vectors;
  int miscompares;

  grf_wb_queue #(
    .DEPTH (4),
    .AW    (5),
    .DW    (32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pc    (in_pc),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .drain_en (drain_en),
    .grf_we   (grf_we),
    .grf_pc   (grf_pc),
    .grf_a3   (grf_a3),
    .grf_wd   (grf_wd),
    .q_addr   (q_addr),
    .q_hit    (q_hit),
    .q_data   (q_data),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_set(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
    in_valid = 1'b1;
    in_pc    = pc;
    in_addr  = a;
    in_data  = d;
  endtask

  task automatic query(input logic [4:0] a);
    q_addr = a;
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_pc       = '0;
    in_addr     = '0;
    in_data     = '0;
    drain_en    = 1'b0;
    q_addr      = '0;

    // Reset state
    step();
    step();
    reset = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_we", 32'(grf_we), 0);
    chk("rst_pc", grf_pc, 0);
    chk("rst_a3", 32'(grf_a3), 0);
    chk("rst_wd", grf_wd, 0);

    // Single write: minimum latency and forwarding along the way
    drain_en = 1'b1;
    push_set(32'h3000, 5'd8, 32'h1234);
    step();
    in_valid = 1'b0;
    chk("single_count_after_push", 32'(count), 1);
    chk("single_we_not_yet", 32'(grf_we), 0);
    query(5'd8);
    chk("single_fwd_fifo_hit", 32'(q_hit), 1);
    chk("single_fwd_fifo_data", q_data, 32'h1234);
    step();
    chk("single_we", 32'(grf_we), 1);
    chk("single_a3", 32'(grf_a3), 8);
    chk("single_wd", grf_wd, 32'h1234);
    chk("single_pc", grf_pc, 32'h3000);
    chk("single_count_after_pop", 32'(count), 0);
    chk("single_fwd_out_hit", 32'(q_hit), 1);
    chk("single_fwd_out_data", q_data, 32'h1234);
    step();
    chk("single_we_drop", 32'(grf_we), 0);
    chk("single_a3_hold", 32'(grf_a3), 8);
    chk("single_fwd_gone", 32'(q_hit), 0);

    // Fill and backpressure
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_set(32'h4000 + 32'(4 * i), 5'(i + 1), 32'h101 + 32'(i));
      step();
    end
    chk("fill_count", 32'(count), 4);
    chk("fill_ready", 32'(in_ready), 0);
    push_set(32'h4010, 5'd5, 32'h105);
    step();
    chk("fill_5th_rejected", 32'(count), 4);
    // Full with a pop on the same edge: push still ignored
    drain_en = 1'b1;
    step();
    in_valid = 1'b0;
    chk("full_pop_push_ignored", 32'(count), 3);
    chk("drain0_we", 32'(grf_we), 1);
    chk("drain0_a3", 32'(grf_a3), 1);
    chk("drain0_wd", grf_wd, 32'h101);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("drain_we", 32'(grf_we), 1);
      chk("drain_a3", 32'(grf_a3), 32'(i + 1));
      chk("drain_wd", grf_wd, 32'h101 + 32'(i));
      chk("drain_pc", grf_pc, 32'h4000 + 32'(4 * i));
    end
    chk("drain_count_zero", 32'(count), 0);
    step();
    chk("drain_we_drop", 32'(grf_we), 0);

    // Simultaneous push/pop at count=2 across pointer wrap
    drain_en = 1'b0;
    push_set(32'h6000, 5'd11, 32'h200);
    step();
    push_set(32'h6004, 5'd12, 32'h201);
    step();
    chk("pp_count_start", 32'(count), 2);
    drain_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      push_set(32'h6008 + 32'(4 * k), 5'(13 + k), 32'h202 + 32'(k));
      step();
      chk("pp_we", 32'(grf_we), 1);
      chk("pp_a3", 32'(grf_a3), 32'(11 + k));
      chk("pp_wd", grf_wd, 32'h200 + 32'(k));
      chk("pp_count", 32'(count), 2);
    end
    in_valid = 1'b0;
    step();
    chk("pp_tail1_wd", grf_wd, 32'h20A);
    chk("pp_tail1_count", 32'(count), 1);
    step();
    chk("pp_tail2_wd", grf_wd, 32'h20B);
    chk("pp_tail2_a3", 32'(grf_a3), 22);
    chk("pp_tail2_count", 32'(count), 0);
    step();
    chk("pp_we_drop", 32'(grf_we), 0);

    // Forwarding priority
    drain_en = 1'b0;
    push_set(32'h7000, 5'd9, 32'd1);
    step();
    push_set(32'h7004, 5'd9, 32'd2);
    step();
    push_set(32'h7008, 5'd10, 32'd3);
    step();
    in_valid = 1'b0;
    chk("fwd_count", 32'(count), 3);
    query(5'd9);
    chk("fwd9_hit", 32'(q_hit), 1);
    chk("fwd9_youngest", q_data, 2);
    query(5'd10);
    chk("fwd10_data", q_data, 3);
    drain_en = 1'b1;
    step();
    drain_en = 1'b0;
    chk("fwd_pop_a3", 32'(grf_a3), 9);
    query(5'd9);
    chk("fwd9_fifo_over_out", q_data, 2);
    query(5'd0);
    chk("fwd0_hit", 32'(q_hit), 0);
    chk("fwd0_data", q_data, 0);
    drain_en = 1'b1;
    step();
    step();
    drain_en = 1'b0;
    chk("fwd_drained_count", 32'(count), 0);
    query(5'd10);
    chk("fwd10_out_hit", 32'(q_hit), 1);
    chk("fwd10_out_data", q_data, 3);
    query(5'd9);
    chk("fwd9_none_hit", 32'(q_hit), 0);
    chk("fwd9_none_data", q_data, 0);
    step();
    query(5'd10);
    chk("fwd10_after_we_drop", 32'(q_hit), 0);

    // Register $0 write is emitted but never forwarded
    drain_en = 1'b1;
    push_set(32'h5000, 5'd0, 32'hFFFF);
    step();
    in_valid = 1'b0;
    query(5'd0);
    chk("r0_fifo_nohit", 32'(q_hit), 0);
    step();
    chk("r0_we", 32'(grf_we), 1);
    chk("r0_a3", 32'(grf_a3), 0);
    chk("r0_wd", grf_wd, 32'hFFFF);
    chk("r0_pc", grf_pc, 32'h5000);
    chk("r0_out_nohit", 32'(q_hit), 0);
    step();

    // Mid-operation reset with entries queued and grf_we high
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_set(32'h8000 + 32'(4 * i), 5'(i + 1), 32'h301 + 32'(i));
      step();
    end
    in_valid = 1'b0;
    drain_en = 1'b1;
    step();
    chk("mr_pre_we", 32'(grf_we), 1);
    chk("mr_pre_count", 32'(count), 3);
    reset = 1'b1;
    push_set(32'h9000, 5'd7, 32'h777);
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("mr_we", 32'(grf_we), 0);
    chk("mr_count", 32'(count), 0);
    chk("mr_ready", 32'(in_ready), 1);
    chk("mr_pc", grf_pc, 0);
    chk("mr_a3", 32'(grf_a3), 0);
    chk("mr_wd", grf_wd, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr_post_we", 32'(grf_we), 0);
      chk("mr_post_count", 32'(count), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
